// File: rtl/parity_pkg.sv
// Shared types and constants for the parity stream checker.
// Holds the frame FSM state encoding and the parity mode encodings.
package parity_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/parity_stream_checker_if.sv
// Beat-in / result-out stream bundle for the parity stream checker.
// master drives beats and result acceptance; slave is the checker.
interface parity_stream_checker_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_par;
   logic              out_valid;
   logic              out_ready;
   logic              out_par;
   logic              out_err;

   modport master (
      output in_valid, in_data, in_last, in_par, out_ready,
      input  in_ready, out_valid, out_par, out_err
   );

   modport slave (
      input  in_valid, in_data, in_last, in_par, out_ready,
      output in_ready, out_valid, out_par, out_err
   );
endinterface

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one data beat to a single parity bit.
// Zero latency; no flow control.
module parity_reduce #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data_i,
   output logic              par_o
);

   assign par_o = ^data_i;

endmodule

// File: rtl/parity_stream_checker.sv
// Accumulates frame parity over a beat stream and reports parity/mismatch once per frame.
// Result is valid the cycle after the last beat; beats stall (in_ready=0) until the result is taken.
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode_odd,
   input  logic                    clr_stats,
   parity_stream_checker_if.slave  bus,
   output logic [CNT_W-1:0]        err_count,
   output logic [CNT_W-1:0]        frame_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic             acc_q, acc_d;
   logic             mode_q, mode_d;
   logic             par_q, par_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;

   logic beat_par;
   logic beat_xfer;
   logic frame_par;
   logic mode_eff;
   logic rpt_entry;

   parity_reduce #(.DATA_W(DATA_W)) u_reduce (
      .data_i (bus.in_data),
      .par_o  (beat_par)
   );

   assign bus.in_ready  = (state_q != ST_REPORT);
   assign bus.out_valid = (state_q == ST_REPORT);
   assign bus.out_par   = par_q;
   assign bus.out_err   = err_q;
   assign err_count     = err_cnt_q;
   assign frame_count   = frm_cnt_q;

   assign beat_xfer = bus.in_valid && bus.in_ready;
   // acc_q is held at 0 while idle, so the first beat folds in cleanly.
   assign frame_par = acc_q ^ beat_par;
   assign mode_eff  = (state_q == ST_IDLE) ? mode_odd : mode_q;
   assign rpt_entry = beat_xfer && bus.in_last;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mode_d  = mode_q;
      par_d   = par_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (beat_xfer) begin
               mode_d = mode_eff;
               if (bus.in_last) begin
                  par_d   = frame_par ^ (mode_eff == MODE_ODD);
                  err_d   = bus.in_par ^ frame_par ^ (mode_eff == MODE_ODD);
                  acc_d   = frame_par;
                  state_d = ST_REPORT;
               end else begin
                  acc_d   = frame_par;
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_REPORT: begin
            if (bus.out_ready) begin
               acc_d   = 1'b0;
               par_d   = 1'b0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            acc_d   = 1'b0;
            par_d   = 1'b0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Clear beats a same-edge increment; counters stick at all-ones.
   always_comb begin
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;
      if (clr_stats) begin
         frm_cnt_d = '0;
         err_cnt_d = '0;
      end else if (rpt_entry) begin
         if (!(&frm_cnt_q)) frm_cnt_d = frm_cnt_q + CNT_ONE;
         if (err_d && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         acc_q     <= 1'b0;
         mode_q    <= MODE_EVEN;
         par_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         frm_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mode_q    <= mode_d;
         par_q     <= par_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         frm_cnt_q <= frm_cnt_d;
      end
   end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker: a DATA_W=8/CNT_W=16 instance for function,
// and a CNT_W=2 instance for counter saturation and clear priority.
module tb_parity_stream_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        mode_odd, clr_stats;
   logic [15:0] err_count, frame_count;
   logic        mode_odd_s, clr_stats_s;
   logic [1:0]  err_count_s, frame_count_s;

   int tests = 0;
   int fails = 0;

   parity_stream_checker_if #(.DATA_W(8)) bus ();
   parity_stream_checker_if #(.DATA_W(8)) bus_s ();

   parity_stream_checker #(.DATA_W(8), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_odd    (mode_odd),
      .clr_stats   (clr_stats),
      .bus         (bus.slave),
      .err_count   (err_count),
      .frame_count (frame_count)
   );

   parity_stream_checker #(.DATA_W(8), .CNT_W(2)) dut_s (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_odd    (mode_odd_s),
      .clr_stats   (clr_stats_s),
      .bus         (bus_s.slave),
      .err_count   (err_count_s),
      .frame_count (frame_count_s)
   );

   task automatic beat(input logic [7:0] d, input logic last, input logic par);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_par   = par;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_par   = 1'b0;
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      tests++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
      tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_beat();
      mode_odd = 1'b0;
      beat(8'h0F, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out_par !== 1'b0 || bus.out_err !== 1'b0) begin fails++; $display("FAIL single_par_err: got %b/%b want 0/0", bus.out_par, bus.out_err); end
      tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL single_frame_count: got %0d want 1", frame_count); end
      @(posedge clk); #1;
      accept();
      @(negedge clk);
      tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_release: got valid %b ready %b want 0/1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_odd_multi();
      // 01,03,07 carry six ones: raw parity 0, odd mode reports 1.
      mode_odd = 1'b1;
      beat(8'h01, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b0);
      beat(8'h07, 1'b1, 1'b1);
      @(negedge clk);
      tests++; if (bus.out_par !== 1'b1 || bus.out_err !== 1'b0) begin fails++; $display("FAIL odd_match: got %b/%b want 1/0", bus.out_par, bus.out_err); end
      tests++; if (err_count !== 16'd0 || frame_count !== 16'd2) begin fails++; $display("FAIL odd_match_counts: got err %0d frames %0d want 0/2", err_count, frame_count); end
      accept();
      beat(8'h01, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b0);
      beat(8'h07, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (bus.out_par !== 1'b1 || bus.out_err !== 1'b1) begin fails++; $display("FAIL odd_mismatch: got %b/%b want 1/1", bus.out_par, bus.out_err); end
      tests++; if (err_count !== 16'd1 || frame_count !== 16'd3) begin fails++; $display("FAIL odd_mismatch_counts: got err %0d frames %0d want 1/3", err_count, frame_count); end
      accept();
   endtask

   task automatic test_backpressure();
      mode_odd = 1'b0;
      beat(8'h07, 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_par !== 1'b1 || bus.out_err !== 1'b0) begin
            fails++;
            $display("FAIL hold_cycle%0d: got ready %b valid %b par %b err %b want 0/1/1/0", i, bus.in_ready, bus.out_valid, bus.out_par, bus.out_err);
         end
      end
      tests++; if (frame_count !== 16'd4) begin fails++; $display("FAIL hold_frame_count: got %0d want 4", frame_count); end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      @(negedge clk);
      tests++; if (bus.out_valid !== 1'b0 || bus.out_par !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release: got valid %b par %b ready %b want 0/0/1", bus.out_valid, bus.out_par, bus.in_ready); end
   endtask

   task automatic test_mode_latch();
      mode_odd = 1'b0;
      beat(8'h01, 1'b0, 1'b0);
      mode_odd = 1'b1;
      beat(8'h00, 1'b1, 1'b1);
      @(negedge clk);
      tests++; if (bus.out_par !== 1'b1 || bus.out_err !== 1'b0) begin fails++; $display("FAIL mode_latch: got %b/%b want 1/0", bus.out_par, bus.out_err); end
      tests++; if (frame_count !== 16'd5) begin fails++; $display("FAIL mode_latch_frames: got %0d want 5", frame_count); end
      accept();
      mode_odd = 1'b0;
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd0;
      for (int k = 0; k < 5; k++) begin
         bus_s.in_valid = 1'b1;
         bus_s.in_data  = 8'h01;
         bus_s.in_last  = 1'b1;
         bus_s.in_par   = 1'b0;
         clr_stats_s    = (k == 4);
         @(posedge clk); #1;
         bus_s.in_valid = 1'b0;
         bus_s.in_last  = 1'b0;
         clr_stats_s    = 1'b0;
         @(negedge clk);
         tests++;
         if (frame_count_s !== exp_cnt[k] || err_count_s !== exp_cnt[k]) begin
            fails++;
            $display("FAIL sat_frame%0d: got frames %0d errs %0d want %0d", k, frame_count_s, err_count_s, exp_cnt[k]);
         end
         tests++; if (bus_s.out_err !== 1'b1) begin fails++; $display("FAIL sat_err%0d: got %b want 1", k, bus_s.out_err); end
         bus_s.out_ready = 1'b1;
         @(posedge clk); #1;
         bus_s.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_midframe();
      beat(8'h01, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (bus.out_valid !== 1'b0 || bus.out_par !== 1'b0 || bus.out_err !== 1'b0) begin fails++; $display("FAIL rst_mid_outputs: got %b/%b/%b want 0/0/0", bus.out_valid, bus.out_par, bus.out_err); end
      tests++; if (frame_count !== 16'd0 || err_count !== 16'd0) begin fails++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", frame_count, err_count); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
      beat(8'h00, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1 || bus.out_par !== 1'b0 || bus.out_err !== 1'b0) begin fails++; $display("FAIL rst_mid_fresh: got valid %b par %b err %b want 1/0/0", bus.out_valid, bus.out_par, bus.out_err); end
      tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL rst_mid_frames: got %0d want 1", frame_count); end
      accept();
   endtask

   initial begin
      mode_odd      = 1'b0;
      clr_stats     = 1'b0;
      mode_odd_s    = 1'b0;
      clr_stats_s   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.in_par    = 1'b0;
      bus.out_ready = 1'b0;
      bus_s.in_valid  = 1'b0;
      bus_s.in_data   = 8'h00;
      bus_s.in_last   = 1'b0;
      bus_s.in_par    = 1'b0;
      bus_s.out_ready = 1'b0;

      test_reset();
      test_single_beat();
      test_odd_multi();
      test_backpressure();
      test_mode_latch();
      test_saturation();
      test_reset_midframe();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
